one_unit_mul1_seq: RTL and testbench
====================================

# one_unit_mul1_seq

Sequencer for the one-unit MUL1 outer-product stage of the FastICA datapath. It loads the 4x4 weight set (w11..w44) word by word, then streams N whitened samples z(4x1) into the multiplier array with `en_mul` gating. It tracks the 1-cycle product latency with a valid/ready pipeline toward the downstream accumulator, and reports iteration completion. It sits between the sample buffer / weight-update logic and the MUL1 array.

## Interface
- `DW`, default 26: fixed-point word width (Q12.13, matches the MUL1 operands).
- `CNT_W`, default 16: sample-counter width.

Ports:
- `clk_seq` in 1: single clock, rising edge.
- `rst_seq` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins an iteration; ignored unless IDLE.
- `n_samples` in CNT_W: samples per iteration; latched on accepted `start`.
- `w_valid` in 1, `w_ready` out 1, `w_data` in DW: weight load handshake; beats arrive row-major w11,w12,…,w44.
- `w_flat` out 16*DW: held weights; word k occupies bits [k*DW +: DW], with k=0 being w11.
- `z_valid` in 1, `z_ready` out 1, `z_in` in 4*DW: sample handshake; z1 is in the low word.
- `en_mul` out 1: multiplier enable, combinational.
- `z_mul` out 4*DW: equals `z_in`, routed to MUL1.
- `mul_valid` out 1: MUL1 output registers hold an unconsumed product.
- `mul_first` out 1, `mul_last` out 1: qualify `mul_valid` for sample 0 and sample n-1.
- `acc_ready` in 1: downstream consumes the product when `mul_valid && acc_ready`.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, LOAD_W, RUN, DRAIN, DONE.
- IDLE, on `start`:
  - latch `n_samples`, clear `w_idx`, `issue_cnt` and `ret_cnt`;
  - go to LOAD_W.
- LOAD_W:
  - `w_ready`=1;
  - each accepted beat writes `w_flat` word `w_idx` and increments `w_idx`;
  - on the beat with `w_idx`==15, go to RUN. If latched n==0, go to DONE instead.
- RUN:
  - `z_ready` = (`issue_cnt` < n) && (!`mul_valid` || `acc_ready`);
  - `en_mul` = `z_valid && z_ready`;
  - each issue increments `issue_cnt` and sets `mul_valid` next cycle;
  - `mul_valid` clears after a consume cycle that has no new issue;
  - a simultaneous consume and issue keeps `mul_valid`=1;
  - after the issue with `issue_cnt`==n-1, go to DRAIN.
- DRAIN:
  - no issues;
  - wait until `ret_cnt` reaches n, i.e. the last product has been consumed;
  - then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `ret_cnt` increments on each consume.
- `mul_first` = `mul_valid` && `ret_cnt`==0.
- `mul_last` = `mul_valid` && `ret_cnt`==n-1.
- `w_flat` holds its value outside LOAD_W. This guarantees the weights stay stable for the whole RUN.
- `en_mul` is never asserted outside RUN, so the MUL1 product registers keep a stalled product.
- `start` outside IDLE is ignored. `w_valid`/`z_valid` outside their states are not accepted.
- Counters compare at CNT_W bits unsigned. n = 2^CNT_W−1 is legal, and no counter wraps.

## Timing
- Reset values: `w_ready`=0, `z_ready`=0, `en_mul`=0, `mul_valid`=0, `mul_first`=0, `mul_last`=0, `busy`=0, `done`=0, `w_flat`=0, all counters 0, state IDLE.
- Reset mid-iteration aborts immediately; the next `start` reloads the weights.
- `start` at cycle t gives `busy`=1 and `w_ready`=1 at t+1.
- The minimum load is 16 cycles.
- Latency from `en_mul` to `mul_valid` is exactly 1 cycle, matching the MUL1 register stage.
- With `z_valid` and `acc_ready` held high, throughput is one sample per cycle.
- `done` asserts the cycle after the final consume.
- Minimum iteration length is 1 + 16 + n + 1 + 1 cycles.
- `acc_ready` low with `mul_valid`=1 deasserts `z_ready` in the same cycle (combinational path `acc_ready` → `z_ready`/`en_mul`).

## Structure
- Shared package `fastica_pkg`:
  - `DW`, the Q-format fraction bits (13);
  - the state enum `seq_state_t`;
  - the weight count constant `N_W=16`.
- Split into:
  - the FSM and counters;
  - one sub-module, `w_load_regfile`, which is 16×DW registers with indexed write and the flat output.
- The top level instantiates `w_load_regfile` alongside the FSM; MUL1 itself stays external.

## Test plan
- Weight load: reset, `start`, n=4, load 16 beats with values 1..16 → `w_flat` word k = k+1 and RUN is entered; `z_ready` is 1 the cycle after beat 16.
- Streaming: n=4, `z_valid` and `acc_ready` held high → `en_mul` high for 4 consecutive cycles, then `mul_valid` high for 4 cycles, `mul_first` on the 1st product, `mul_last` on the 4th, `done` 1 cycle later.
- Backpressure: `acc_ready`=0 for 3 cycles with `mul_valid`=1 → `z_ready`/`en_mul` are 0 throughout and no sample is lost; total consumes = n=8 and `done` fires once.
- n=0: after the 16 weight beats → DONE, then IDLE; `en_mul` never asserts and `mul_valid` stays 0.
- Reset: assert `rst_seq` mid-RUN (`issue_cnt`=2) → all outputs return to their reset values asynchronously; a subsequent `start` with n=3 runs cleanly, and `start` pulsed during RUN has no effect.

Source files
------------

// File: rtl/fastica_pkg.sv
// Shared constants and types for the FastICA MUL1 sequencer.
// Word format is Q12.13 (DW total bits, Q_FRAC fraction bits).
package fastica_pkg;

  localparam int DW     = 26;
  localparam int Q_FRAC = 13;
  localparam int N_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/one_unit_mul1_seq_if.sv
// Handshake bundle between the sample/weight sources, the sequencer,
// the MUL1 array and the downstream accumulator.
interface one_unit_mul1_seq_if #(
  parameter int DW    = fastica_pkg::DW,
  parameter int CNT_W = 16
);

  logic             start;
  logic [CNT_W-1:0] n_samples;

  logic             w_valid;
  logic             w_ready;
  logic [DW-1:0]    w_data;
  logic [16*DW-1:0] w_flat;

  logic             z_valid;
  logic             z_ready;
  logic [4*DW-1:0]  z_in;

  logic             en_mul;
  logic [4*DW-1:0]  z_mul;
  logic             mul_valid;
  logic             mul_first;
  logic             mul_last;
  logic             acc_ready;

  logic             busy;
  logic             done;

  modport master (
    output start, n_samples,
    output w_valid, w_data,
    output z_valid, z_in,
    output acc_ready,
    input  w_ready, w_flat,
    input  z_ready, en_mul, z_mul,
    input  mul_valid, mul_first, mul_last,
    input  busy, done
  );

  modport slave (
    input  start, n_samples,
    input  w_valid, w_data,
    input  z_valid, z_in,
    input  acc_ready,
    output w_ready, w_flat,
    output z_ready, en_mul, z_mul,
    output mul_valid, mul_first, mul_last,
    output busy, done
  );

endinterface

// File: rtl/w_load_regfile.sv
// 16-word weight register file with indexed write; the flat output
// only changes on a write, so weights stay frozen while streaming.
module w_load_regfile #(
  parameter int DW = fastica_pkg::DW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [$clog2(fastica_pkg::N_W)-1:0] idx,
  input  logic [DW-1:0]                   wdata,
  output logic [fastica_pkg::N_W*DW-1:0]  w_flat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_flat <= '0;
    end else if (we) begin
      w_flat[idx*DW +: DW] <= wdata;
    end
  end

endmodule

// File: rtl/one_unit_mul1_seq.sv
// MUL1 sequencer: weight load, sample issue with a one-deep product
// stage toward the accumulator, drain and completion pulse.
module one_unit_mul1_seq #(
  parameter int DW    = fastica_pkg::DW,
  parameter int CNT_W = 16
) (
  input logic                 clk_seq,
  input logic                 rst_seq,
  one_unit_mul1_seq_if.slave  bus
);

  import fastica_pkg::seq_state_t;
  import fastica_pkg::S_IDLE;
  import fastica_pkg::S_LOAD_W;
  import fastica_pkg::S_RUN;
  import fastica_pkg::S_DRAIN;
  import fastica_pkg::S_DONE;
  import fastica_pkg::N_W;

  localparam int IW = $clog2(N_W);

  seq_state_t       state;
  seq_state_t       state_nx;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] n_m1;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [IW-1:0]    w_idx;
  logic             mul_valid;
  logic             load_beat;
  logic             last_beat;
  logic             z_rdy;
  logic             issue;
  logic             consume;

  assign n_m1      = n_lat - CNT_W'(1);
  assign load_beat = (state == S_LOAD_W) && bus.w_valid;
  assign last_beat = load_beat && (w_idx == IW'(N_W - 1));
  assign consume   = mul_valid && bus.acc_ready;

  // acc_ready feeds z_ready directly so a stalled product is never overwritten
  assign z_rdy = (state == S_RUN)
              && (issue_cnt < n_lat)
              && (!mul_valid || bus.acc_ready);
  assign issue = z_rdy && bus.z_valid;

  always_ff @(posedge clk_seq or posedge rst_seq) begin
    if (rst_seq) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (last_beat) begin
          state_nx = (n_lat == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (issue_cnt == n_m1)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (consume && (ret_cnt == n_m1)) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_seq or posedge rst_seq) begin
    if (rst_seq) begin
      n_lat     <= '0;
      w_idx     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      mul_valid <= 1'b0;
    end else if ((state == S_IDLE) && bus.start) begin
      n_lat     <= bus.n_samples;
      w_idx     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      mul_valid <= 1'b0;
    end else begin
      if (load_beat) w_idx     <= w_idx + IW'(1);
      if (issue)     issue_cnt <= issue_cnt + CNT_W'(1);
      if (consume)   ret_cnt   <= ret_cnt + CNT_W'(1);
      if (issue) begin
        mul_valid <= 1'b1;
      end else if (consume) begin
        mul_valid <= 1'b0;
      end
    end
  end

  w_load_regfile #(
    .DW (DW)
  ) u_wregs (
    .clk    (clk_seq),
    .rst    (rst_seq),
    .we     (load_beat),
    .idx    (w_idx),
    .wdata  (bus.w_data),
    .w_flat (bus.w_flat)
  );

  assign bus.w_ready   = (state == S_LOAD_W);
  assign bus.z_ready   = z_rdy;
  assign bus.en_mul    = issue;
  assign bus.z_mul     = bus.z_in;
  assign bus.mul_valid = mul_valid;
  assign bus.mul_first = mul_valid && (ret_cnt == '0);
  assign bus.mul_last  = mul_valid && (ret_cnt == n_m1);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);

endmodule

// File: tb/tb_one_unit_mul1_seq.sv
// Scoreboard bench for one_unit_mul1_seq with a behavioural MUL1 stage
// and randomized weight/sample/backpressure traffic.
module tb_one_unit_mul1_seq;

  localparam int DW    = 26;
  localparam int CNT_W = 16;
  localparam int WW    = 16 * DW;
  localparam int ZW    = 4 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  one_unit_mul1_seq_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  one_unit_mul1_seq #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk_seq (clk),
    .rst_seq (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [ZW-1:0] data;
    logic          first;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            errors    = 0;
  int            checks    = 0;
  int            acc_mode  = 0;
  int            lows_left = 0;
  int            n_cons    = 0;
  int            n_mulv    = 0;
  int            n_en      = 0;
  logic [ZW-1:0] mul_reg;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [WW-1:0] act,
                      input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [ZW-1:0] rand_z();
    return ZW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // MUL1 product register: captures the routed operands on en_mul
  always @(posedge clk) begin
    if (bus.en_mul) begin
      mul_reg <= bus.z_mul;
      n_en    <= n_en + 1;
    end
  end

  always @(negedge clk) begin
    case (acc_mode)
      0: bus.acc_ready = 1'b1;
      1: bus.acc_ready = ($urandom % 3) != 0;
      default: begin
        if (bus.mul_valid && lows_left > 0) begin
          bus.acc_ready = 1'b0;
          lows_left--;
        end else begin
          bus.acc_ready = 1'b1;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (bus.mul_valid) n_mulv++;
      if (!bus.mul_valid) begin
        chk1("idle_mul_first", bus.mul_first, 1'b0);
        chk1("idle_mul_last", bus.mul_last, 1'b0);
      end
      if (bus.mul_valid && !bus.acc_ready) begin
        chk1("stall_z_ready", bus.z_ready, 1'b0);
        chk1("stall_en_mul", bus.en_mul, 1'b0);
      end
      if (bus.mul_valid && bus.acc_ready) begin
        n_cons++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL consume_underflow: got product with empty queue");
        end else begin
          e = sb.pop_front();
          chkw("product_data", WW'(mul_reg), WW'(e.data));
          chk1("mul_first", bus.mul_first, e.first);
          chk1("mul_last", bus.mul_last, e.last);
        end
      end
    end
  end

  task automatic run_iter(input int n, input bit fast, input int amode,
                          input bit abort2, input bit start_in_run,
                          input bit seq_w);
    logic [DW-1:0] w[16];
    logic [WW-1:0] wexp;
    logic [ZW-1:0] cur;
    exp_t          e;
    int            k, i, c, done_c;
    bit            got;
    for (int j = 0; j < 16; j++) begin
      w[j] = seq_w ? DW'(j + 1) : DW'($urandom);
      wexp[j*DW +: DW] = w[j];
    end
    acc_mode  = amode;
    lows_left = 3;
    n_cons    = 0;
    n_mulv    = 0;
    n_en      = 0;
    sb.delete();
    @(negedge clk);
    c = 0;
    bus.start     = 1'b1;
    bus.n_samples = CNT_W'(n);
    #1;
    chk1("idle_busy", bus.busy, 1'b0);
    k = 0;
    while (k < 16 && c < 400) begin
      @(negedge clk);
      c++;
      bus.start     = 1'b0;
      bus.n_samples = CNT_W'($urandom);
      bus.w_valid   = fast || (($urandom % 4) != 0);
      bus.w_data    = w[k];
      #1;
      if (c == 1) begin
        chk1("start_busy", bus.busy, 1'b1);
        chk1("start_w_ready", bus.w_ready, 1'b1);
      end
      if (bus.w_valid && bus.w_ready) k++;
    end
    chki("weight_beats", k, 16);
    cur    = rand_z();
    i      = 0;
    got    = 1'b0;
    done_c = -1;
    for (int g = 0; g < 400 + 8 * n && !got; g++) begin
      @(negedge clk);
      c++;
      bus.w_valid = 1'b0;
      bus.start   = start_in_run && (g == 1);
      if (abort2 && i == 2) begin
        bus.z_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk1("rst_w_ready", bus.w_ready, 1'b0);
        chk1("rst_z_ready", bus.z_ready, 1'b0);
        chk1("rst_en_mul", bus.en_mul, 1'b0);
        chk1("rst_mul_valid", bus.mul_valid, 1'b0);
        chk1("rst_mul_first", bus.mul_first, 1'b0);
        chk1("rst_mul_last", bus.mul_last, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chkw("rst_w_flat", bus.w_flat, '0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      bus.z_valid = (i < n) && (fast || (($urandom % 3) != 0));
      bus.z_in    = cur;
      #1;
      if (g == 0) begin
        chkw("w_flat", bus.w_flat, wexp);
        if (n > 0) chk1("run_z_ready", bus.z_ready, 1'b1);
      end
      if (bus.z_valid && bus.z_ready) begin
        e.data  = cur;
        e.first = (i == 0);
        e.last  = (i == n - 1);
        sb.push_back(e);
        i++;
        cur = rand_z();
      end
      if (bus.done) begin
        got    = 1'b1;
        done_c = c;
      end
    end
    chk1("done_seen", got, 1'b1);
    if (fast && amode == 0) chki("done_cycle", done_c, (n > 0) ? n + 18 : 17);
    @(negedge clk);
    bus.z_valid = 1'b0;
    #1;
    chk1("done_one_cycle", bus.done, 1'b0);
    chk1("idle_after_done", bus.busy, 1'b0);
    chki("issued", i, n);
    chki("consumed", n_cons, n);
    chki("en_mul_count", n_en, n);
    chki("queue_empty", sb.size(), 0);
    if (n == 0) chki("n0_mul_valid_cycles", n_mulv, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.n_samples = '0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.z_valid   = 1'b0;
    bus.z_in      = '0;
    repeat (2) @(negedge clk);
    #1;
    chk1("reset_busy", bus.busy, 1'b0);
    chk1("reset_w_ready", bus.w_ready, 1'b0);
    chk1("reset_z_ready", bus.z_ready, 1'b0);
    chk1("reset_en_mul", bus.en_mul, 1'b0);
    chk1("reset_mul_valid", bus.mul_valid, 1'b0);
    chk1("reset_mul_first", bus.mul_first, 1'b0);
    chk1("reset_mul_last", bus.mul_last, 1'b0);
    chk1("reset_done", bus.done, 1'b0);
    chkw("reset_w_flat", bus.w_flat, '0);
    @(negedge clk);
    rst = 1'b0;

    run_iter(4, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    run_iter(8, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    run_iter(0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    run_iter(4, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    run_iter(3, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      run_iter($urandom_range(1, 12), 1'b0, 1, 1'b0, 1'b0, 1'b0);
    end
    run_iter(1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    run_iter(0, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
